// File: rtl/peasant_div_nxn.sv
// rtl/peasant_div_nxn.sv - restoring shift-subtract divider, one quotient bit per clock
// Optional macro PEASANT_DIV_SIGNED_EN selects two's-complement operands (sign fix on completion edge).
module peasant_div_nxn #(
    parameter int n = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [n-1:0] data0_i,
    input  logic [n-1:0] data1_i,
    output logic [n-1:0] q_o,
    output logic [n-1:0] r_o,
    output logic         fl_o,
    output logic         busy_o,
    output logic         dz_o
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [n-1:0]   rem_q, rem_d;
    logic [n-1:0]   quo_q, quo_d;
    logic [n-1:0]   dvs_q, dvs_d;
    logic [n-1:0]   q_q, q_d;
    logic [n-1:0]   r_q, r_d;
    logic           fl_q, fl_d;
    logic           dz_q, dz_d;

    logic [n:0]     shifted, trial;
    logic [n-1:0]   rem_nx, quo_nx;
    logic [n-1:0]   a_op, b_op, q_fix, r_fix;

`ifdef PEASANT_DIV_SIGNED_EN
    logic negq_q, negq_d, negr_q, negr_d;

    assign a_op  = data0_i[n-1] ? -data0_i : data0_i;
    assign b_op  = data1_i[n-1] ? -data1_i : data1_i;
    // Quotient is negative when signs differ; remainder follows the dividend.
    assign q_fix = negq_q ? -quo_nx : quo_nx;
    assign r_fix = negr_q ? -rem_nx : rem_nx;
`else
    assign a_op  = data0_i;
    assign b_op  = data1_i;
    assign q_fix = quo_nx;
    assign r_fix = rem_nx;
`endif

    // Partial remainder is always below the divisor, so n bits hold it between iterations.
    always_comb begin
        shifted = {rem_q, quo_q[n-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[n]) begin
            rem_nx = trial[n-1:0];
            quo_nx = {quo_q[n-2:0], 1'b1};
        end else begin
            rem_nx = shifted[n-1:0];
            quo_nx = {quo_q[n-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        fl_d    = fl_q;
        dz_d    = dz_q;
`ifdef PEASANT_DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    if (data1_i != '0) begin
                        state_d = RUN;
                        cnt_d   = CW'(n - 1);
                        rem_d   = '0;
                        quo_d   = a_op;
                        dvs_d   = b_op;
                        fl_d    = 1'b0;
                        dz_d    = 1'b0;
`ifdef PEASANT_DIV_SIGNED_EN
                        negq_d  = data0_i[n-1] ^ data1_i[n-1];
                        negr_d  = data0_i[n-1];
`endif
                    end else begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = data0_i;
                        fl_d    = 1'b1;
                        dz_d    = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    q_d     = q_fix;
                    r_d     = r_fix;
                    fl_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            fl_q    <= 1'b0;
            dz_q    <= 1'b0;
`ifdef PEASANT_DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            fl_q    <= fl_d;
            dz_q    <= dz_d;
`ifdef PEASANT_DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign q_o    = q_q;
    assign r_o    = r_q;
    assign fl_o   = fl_q;
    assign dz_o   = dz_q;
    assign busy_o = (state_q == RUN);
endmodule

// File: tb/tb_peasant_div_nxn.sv
// tb/tb_peasant_div_nxn.sv - self-checking bench for peasant_div_nxn
module tb_peasant_div_nxn;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [N-1:0] data0_i = '0;
    logic [N-1:0] data1_i = '0;
    logic [N-1:0] q_o, r_o;
    logic         fl_o, busy_o, dz_o;

    int errors = 0;
    int checks = 0;

    peasant_div_nxn #(.n(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .q_o     (q_o),
        .r_o     (r_o),
        .fl_o    (fl_o),
        .busy_o  (busy_o),
        .dz_o    (dz_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
        data0_i = a;
        data1_i = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Counts edges after the start edge until fl_o rises; bounded at 40.
    task automatic wait_done(output int cyc, output int busy_bad);
        cyc = 0;
        busy_bad = 0;
        while (!fl_o && cyc < 40) begin
            if (!busy_o) busy_bad++;
            step();
            cyc++;
        end
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] eq, output logic [N-1:0] er,
                                  output logic edz);
        int sa, sb, iq, ir;
        if (b == '0) begin
            eq = '1; er = a; edz = 1'b1;
        end else begin
            edz = 1'b0;
`ifdef PEASANT_DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            iq = sa / sb;
            ir = sa % sb;
            eq = iq[N-1:0];
            er = ir[N-1:0];
        end
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        checks++;
        if ({q_o, r_o, fl_o, busy_o, dz_o} !== '0) begin
            errors++;
            $display("FAIL reset: q=%h r=%h fl=%b busy=%b dz=%b, required all 0", q_o, r_o, fl_o, busy_o, dz_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cyc, bb;
        do_start(16'd100, 16'd7);
        checks++;
        if (busy_o !== 1'b1 || fl_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: busy=%b fl=%b, required 1 0", busy_o, fl_o);
        end
        wait_done(cyc, bb);
        checks++;
        if (cyc != N || bb != 0) begin
            errors++;
            $display("FAIL basic_latency: cycles=%0d busy_gaps=%0d, required %0d 0", cyc, bb, N);
        end
        checks++;
        if (q_o !== 16'd14 || r_o !== 16'd2 || dz_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b, required 14 2 0 0", q_o, r_o, dz_o, busy_o);
        end
        repeat (10) step();
        checks++;
        if (q_o !== 16'd14 || r_o !== 16'd2 || fl_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold: q=%0d r=%0d fl=%b, required 14 2 1", q_o, r_o, fl_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bb;
        do_start(16'hFFFF, 16'd1);
        wait_done(cyc, bb);
        checks++;
        if (cyc != N || q_o !== 16'hFFFF || r_o !== 16'd0) begin
            errors++;
            $display("FAIL max_div1: cycles=%0d q=%h r=%h, required %0d ffff 0", cyc, q_o, r_o, N);
        end
        do_start(16'd3, 16'd10);
        checks++;
        if (fl_o !== 1'b0 || busy_o !== 1'b1 || q_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL b2b_start: fl=%b busy=%b q=%h, required 0 1 ffff", fl_o, busy_o, q_o);
        end
        wait_done(cyc, bb);
        checks++;
        if (cyc != N || bb != 0 || q_o !== 16'd0 || r_o !== 16'd3) begin
            errors++;
            $display("FAIL b2b_result: cycles=%0d gaps=%0d q=%0d r=%0d, required %0d 0 0 3", cyc, bb, q_o, r_o, N);
        end
    endtask

    task automatic test_div_zero();
        do_start(16'd5, 16'd0);
        checks++;
        if (fl_o !== 1'b1 || dz_o !== 1'b1 || busy_o !== 1'b0 || q_o !== 16'hFFFF || r_o !== 16'd5) begin
            errors++;
            $display("FAIL div_zero: fl=%b dz=%b busy=%b q=%h r=%0d, required 1 1 0 ffff 5", fl_o, dz_o, busy_o, q_o, r_o);
        end
    endtask

    task automatic test_start_during_run();
        int cyc, bb;
        do_start(16'd1000, 16'd9);
        repeat (4) step();
        do_start(16'd50, 16'd5);
        wait_done(cyc, bb);
        checks++;
        if (cyc + 5 != N || q_o !== 16'd111 || r_o !== 16'd1) begin
            errors++;
            $display("FAIL ignore_start: cycles=%0d q=%0d r=%0d, required %0d 111 1", cyc + 5, q_o, r_o, N);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bb;
        do_start(16'd1000, 16'd9);
        repeat (7) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if ({q_o, r_o, fl_o, busy_o, dz_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset: q=%h r=%h fl=%b busy=%b dz=%b, required all 0", q_o, r_o, fl_o, busy_o, dz_o);
        end
        step(); step();
        checks++;
        if (fl_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: fl=%b busy=%b, required 0 0", fl_o, busy_o);
        end
        do_start(16'd12, 16'd4);
        wait_done(cyc, bb);
        checks++;
        if (cyc != N || q_o !== 16'd3 || r_o !== 16'd0) begin
            errors++;
            $display("FAIL after_reset: cycles=%0d q=%0d r=%0d, required %0d 3 0", cyc, q_o, r_o, N);
        end
    endtask

    task automatic test_random();
        int cyc, bb;
        logic [N-1:0] a, b, eq, er;
        logic edz;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'($urandom_range(1, 15));
                1: b = 16'($urandom);
                2: b = (i % 8 == 2) ? 16'd0 : 16'($urandom_range(1, 300));
                default: b = a + 16'($urandom_range(0, 3));
            endcase
            model(a, b, eq, er, edz);
            do_start(a, b);
            data0_i = 16'($urandom);
            data1_i = 16'($urandom);
            wait_done(cyc, bb);
            checks++;
            if (q_o !== eq || r_o !== er || dz_o !== edz || cyc != (edz ? 0 : N) || bb != 0) begin
                errors++;
                $display("FAIL random[%0d] %h/%h: q=%h r=%h dz=%b cyc=%0d, required %h %h %b %0d",
                         i, a, b, q_o, r_o, dz_o, cyc, eq, er, edz, edz ? 0 : N);
            end
        end
    endtask

`ifdef PEASANT_DIV_SIGNED_EN
    task automatic test_signed();
        int cyc, bb;
        logic [N-1:0] va [3] = '{16'hFFF9, 16'd7,    16'h8000};
        logic [N-1:0] vb [3] = '{16'd2,    16'hFFFE, 16'hFFFF};
        logic [N-1:0] vq [3] = '{16'hFFFD, 16'hFFFD, 16'h8000};
        logic [N-1:0] vr [3] = '{16'hFFFF, 16'd1,    16'd0};
        for (int i = 0; i < 3; i++) begin
            do_start(va[i], vb[i]);
            wait_done(cyc, bb);
            checks++;
            if (cyc != N || q_o !== vq[i] || r_o !== vr[i] || dz_o !== 1'b0) begin
                errors++;
                $display("FAIL signed[%0d]: cycles=%0d q=%h r=%h dz=%b, required %0d %h %h 0",
                         i, cyc, q_o, r_o, dz_o, N, vq[i], vr[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
`ifdef PEASANT_DIV_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
